// File: rtl/maxpool_layer_sequencer.sv
// Layer sequencer for the max-pool HLS core: runs a table of per-layer shapes through ap_ctrl_hs.
// Optional per-layer cycle counter enabled by defining MAXPOOL_SEQ_PERF_EN.
module maxpool_layer_sequencer #(
  parameter int unsigned MAX_LAYERS = 4,
  parameter int unsigned DIM_W      = 10,
  parameter int unsigned CH_W       = 10,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned IW        = $clog2(MAX_LAYERS),
  localparam int unsigned CFG_W     = CH_W + 2 * DIM_W + 2
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [CFG_W-1:0]  cfg_wdata,
  input  logic [IW:0]       num_layers,
  input  logic              go,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IW-1:0]     layer_idx,
  output logic              core_ap_start,
  input  logic              core_ap_ready,
  input  logic              core_ap_done,
  output logic [CH_W-1:0]   core_channels,
  output logic [DIM_W-1:0]  core_height,
  output logic [DIM_W-1:0]  core_width,
  output logic [1:0]        core_stride,
  output logic [CNT_W-1:0]  perf_cycles,
  output logic              perf_valid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CFG_W-1:0] table_q [MAX_LAYERS];
  logic [CFG_W-1:0] table_d [MAX_LAYERS];
  logic [IW:0]      nlay_q, nlay_d;
  logic [IW-1:0]    layer_idx_q, layer_idx_d;
  logic             abort_pend_q, abort_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;

  // Next-state, table write and registered-output decode
  always_comb begin
    state_d      = state_q;
    table_d      = table_q;
    nlay_d       = nlay_q;
    layer_idx_d  = layer_idx_q;
    abort_pend_d = abort_pend_q;
    cfg_d        = cfg_q;
    err_d        = 1'b0;

    if (state_q == S_IDLE && cfg_we) table_d[cfg_idx] = cfg_wdata;

    case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (go) begin
          if (num_layers != '0 && num_layers <= (IW+1)'(MAX_LAYERS)) begin
            nlay_d      = num_layers;
            layer_idx_d = '0;
            state_d     = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        cfg_d = table_q[layer_idx_q];
        if (abort) begin
          abort_pend_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (abort) abort_pend_d = 1'b1;
        if (core_ap_ready) state_d = core_ap_done ? S_NEXT : S_RUN;
      end
      S_RUN: begin
        if (abort) abort_pend_d = 1'b1;
        if (core_ap_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        if ((IW+1)'(layer_idx_q) == nlay_q - (IW+1)'(1) || abort_pend_q) begin
          state_d = S_DONE;
        end else begin
          layer_idx_d = layer_idx_q + IW'(1);
          state_d     = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the upcoming state so they appear registered with it
    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    if (state_d == S_DONE && abort_pend_d) err_d = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < int'(MAX_LAYERS); i++) table_q[i] <= '0;
      nlay_q       <= '0;
      layer_idx_q  <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      cfg_q        <= '0;
    end else begin
      state_q      <= state_d;
      table_q      <= table_d;
      nlay_q       <= nlay_d;
      layer_idx_q  <= layer_idx_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      start_q      <= start_d;
      cfg_q        <= cfg_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign layer_idx     = layer_idx_q;
  assign core_ap_start = start_q;
  assign core_channels = cfg_q[CH_W-1:0];
  assign core_height   = cfg_q[CH_W+DIM_W-1:CH_W];
  assign core_width    = cfg_q[CH_W+2*DIM_W-1:CH_W+DIM_W];
  assign core_stride   = cfg_q[CFG_W-1:CFG_W-2];

`ifdef MAXPOOL_SEQ_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] perf_q, perf_d;
  logic             perf_valid_q, perf_valid_d;
  logic             in_core;

  // Saturating per-layer counter; the ap_done cycle is included via cnt_inc on exit
  always_comb begin
    in_core      = (state_q == S_START) || (state_q == S_RUN);
    cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_d        = cnt_q;
    perf_d       = perf_q;
    perf_valid_d = 1'b0;
    if (state_q == S_LOAD && state_d == S_START) cnt_d = '0;
    else if (in_core)                             cnt_d = cnt_inc;
    if (in_core && state_d == S_NEXT) begin
      perf_d       = cnt_inc;
      perf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt_q        <= '0;
      perf_q       <= '0;
      perf_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      perf_q       <= perf_d;
      perf_valid_q <= perf_valid_d;
    end
  end

  assign perf_cycles = perf_q;
  assign perf_valid  = perf_valid_q;
`else
  assign perf_cycles = '0;
  assign perf_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_maxpool_layer_sequencer.sv
// Directed bench for maxpool_layer_sequencer with a behavioural ap_ctrl_hs core model.
module tb_maxpool_layer_sequencer;

  localparam int unsigned IW    = 2;
  localparam int unsigned CFG_W = 32;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [IW-1:0]    cfg_idx = '0;
  logic [CFG_W-1:0] cfg_wdata = '0;
  logic [IW:0]      num_layers = '0;
  logic             go = 1'b0;
  logic             abort = 1'b0;
  logic             busy, done, err, core_ap_start, perf_valid;
  logic [IW-1:0]    layer_idx;
  logic             core_ap_ready = 1'b0;
  logic             core_ap_done = 1'b0;
  logic [9:0]       core_channels, core_height, core_width;
  logic [1:0]       core_stride;
  logic [31:0]      perf_cycles;

  maxpool_layer_sequencer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_wdata(cfg_wdata), .num_layers(num_layers), .go(go), .abort(abort),
    .busy(busy), .done(done), .err(err), .layer_idx(layer_idx),
    .core_ap_start(core_ap_start), .core_ap_ready(core_ap_ready), .core_ap_done(core_ap_done),
    .core_channels(core_channels), .core_height(core_height), .core_width(core_width),
    .core_stride(core_stride), .perf_cycles(perf_cycles), .perf_valid(perf_valid)
  );

  always #5 ap_clk = ~ap_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Monitor and core model state
  int cyc = 0;
  int rdy_delay = 0;
  int done_delay = 10;
  int n_rise, n_cd, n_pv, done_cnt, err_cnt, done_cyc, err_cyc;
  int busy_cnt, busy_rise, busy_fall, max_idx, perf_nz;
  int rise_cyc [8], start_len [8], snap_ch [8], snap_h [8], snap_w [8], snap_s [8], snap_idx [8];
  int cd_cyc [8], pv_val [8];
  bit start_prev = 1'b0, busy_prev = 1'b0, inflt = 1'b0;
  int sc = 0, rc = 0;

  initial begin
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (core_ap_start) begin
        if (!start_prev) begin
          if (n_rise < 8) begin
            rise_cyc[n_rise] = cyc;   start_len[n_rise] = 0;
            snap_ch[n_rise]  = int'(core_channels); snap_h[n_rise] = int'(core_height);
            snap_w[n_rise]   = int'(core_width);    snap_s[n_rise] = int'(core_stride);
            snap_idx[n_rise] = int'(layer_idx);
          end
          n_rise++;
        end
        if (n_rise >= 1 && n_rise <= 8) start_len[n_rise-1]++;
      end
      start_prev = core_ap_start;
      if (busy) begin
        busy_cnt++;
        if (!busy_prev) busy_rise = cyc;
        if (int'(layer_idx) > max_idx) max_idx = int'(layer_idx);
      end else if (busy_prev) begin
        busy_fall = cyc;
      end
      busy_prev = busy;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err)  begin err_cnt++;  err_cyc  = cyc; end
      if (perf_valid) begin
        if (n_pv < 8) pv_val[n_pv] = int'(perf_cycles);
        n_pv++;
      end
      if (perf_cycles != '0) perf_nz++;
      // Core model: ready after rdy_delay start cycles, done done_delay cycles after ready
      core_ap_ready = 1'b0;
      core_ap_done  = 1'b0;
      if (inflt) begin
        rc++;
        if (rc >= done_delay) begin
          core_ap_done = 1'b1; inflt = 1'b0; sc = 0;
          if (n_cd < 8) cd_cyc[n_cd] = cyc;
          n_cd++;
        end
      end else if (core_ap_start) begin
        if (sc >= rdy_delay) begin core_ap_ready = 1'b1; inflt = 1'b1; rc = 0; end
        else sc++;
      end
    end
  end

  task automatic clear_mon();
    @(negedge ap_clk);
    #1;
    n_rise = 0; n_cd = 0; n_pv = 0; done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -2;
    busy_cnt = 0; busy_rise = -1; busy_fall = -1; max_idx = 0; perf_nz = 0;
  endtask

  task automatic wr(input int idx, input logic [CFG_W-1:0] data);
    @(negedge ap_clk);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_wdata = data;
    @(negedge ap_clk);
    cfg_we = 1'b0;
  endtask

  task automatic go_pulse(input int n);
    @(negedge ap_clk);
    num_layers = 3'(n); go = 1'b1;
    @(negedge ap_clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (3) @(negedge ap_clk);
    while (busy && n < 400) begin @(negedge ap_clk); n++; end
    check({tag, "_idle_timeout"}, int'(busy), 0);
    repeat (2) @(negedge ap_clk);
  endtask

  task automatic wait_rise(input int k);
    int n = 0;
    while (n_rise < k && n < 200) begin @(negedge ap_clk); n++; end
    check("rise_timeout", int'(n_rise >= k), 1);
  endtask

  function automatic logic [CFG_W-1:0] pack(input int s, input int w, input int h, input int c);
    return {2'(s), 10'(w), 10'(h), 10'(c)};
  endfunction

  initial begin
    clear_mon();
    // Reset held with go asserted
    ap_rst_n = 1'b0; go = 1'b1; num_layers = 3'd1;
    repeat (3) @(negedge ap_clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done_err", int'({done, err}), 0);
    check("rst_start", int'(core_ap_start), 0);
    check("rst_idx", int'(layer_idx), 0);
    check("rst_cfg", int'({core_stride, core_width, core_height, core_channels}), 0);
    check("rst_perf", int'({perf_valid, perf_cycles}), 0);
    check("rst_no_rise", n_rise, 0);
    go = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Two-layer run
    wr(0, pack(1, 416, 416, 16));
    wr(1, pack(2, 208, 208, 32));
    clear_mon();
    go_pulse(2);
    wait_idle("two");
    check("two_rises", n_rise, 2);
    check("two_first_start_lat", rise_cyc[0] - busy_rise, 1);
    check("two_gap", rise_cyc[1] - cd_cyc[0], 3);
    check("two_len0", start_len[0], 1);
    check("two_l0_ch", snap_ch[0], 16);
    check("two_l0_hw", snap_h[0] * 1000 + snap_w[0], 416416);
    check("two_l0_s", snap_s[0], 1);
    check("two_l1_ch", snap_ch[1], 32);
    check("two_l1_hw", snap_h[1] * 1000 + snap_w[1], 208208);
    check("two_l1_s", snap_s[1], 2);
    check("two_l1_idx", snap_idx[1], 1);
    check("two_done_cnt", done_cnt, 1);
    check("two_done_lat", done_cyc - cd_cyc[1], 2);
    check("two_busy_fall", busy_fall - done_cyc, 1);
    check("two_err", err_cnt, 0);
    check("two_cfg_hold_idle", int'(core_channels), 32);
`ifdef MAXPOOL_SEQ_PERF_EN
    check("two_pv_cnt", n_pv, 2);
    check("two_perf0", pv_val[0], 11);
    check("two_perf1", pv_val[1], 11);
    check("two_perf_hold", int'(perf_cycles), 11);
`else
    check("two_pv_cnt", n_pv, 0);
    check("two_perf_zero", perf_nz, 0);
`endif

    // Ready withheld for 5 cycles
    rdy_delay = 5;
    clear_mon();
    go_pulse(1);
    wait_idle("rdy");
    rdy_delay = 0;
    check("rdy_rises", n_rise, 1);
    check("rdy_start_len", start_len[0], 6);
    check("rdy_done_lat", done_cyc - cd_cyc[0], 2);

    // Bad layer counts
    clear_mon();
    go_pulse(0);
    repeat (3) @(negedge ap_clk);
    go_pulse(5);
    repeat (3) @(negedge ap_clk);
    check("bad_err_cnt", err_cnt, 2);
    check("bad_busy", busy_cnt, 0);
    check("bad_done", done_cnt, 0);
    check("bad_rises", n_rise, 0);

    // Maximum layer count runs every entry
    wr(2, pack(0, 20, 10, 3));
    wr(3, pack(3, 7, 9, 5));
    clear_mon();
    go_pulse(4);
    wait_idle("four");
    check("four_rises", n_rise, 4);
    check("four_l3_idx", snap_idx[3], 3);
    check("four_l3_cfg", snap_ch[3] * 1000000 + snap_h[3] * 1000 + snap_w[3], 5009007);
    check("four_l2_s", snap_s[2], 0);
    check("four_done", done_cnt, 1);

    // Abort during RUN of layer 0 of 3
    clear_mon();
    go_pulse(3);
    wait_rise(1);
    repeat (3) @(negedge ap_clk);
    abort = 1'b1;
    @(negedge ap_clk);
    abort = 1'b0;
    wait_idle("abrun");
    check("abrun_max_idx", max_idx, 0);
    check("abrun_rises", n_rise, 1);
    check("abrun_done", done_cnt, 1);
    check("abrun_err", err_cnt, 1);
    check("abrun_done_lat", done_cyc - cd_cyc[0], 2);
    check("abrun_err_with_done", err_cyc, done_cyc);

    // Abort during LOAD
    clear_mon();
    @(negedge ap_clk);
    num_layers = 3'd2; go = 1'b1;
    @(negedge ap_clk);
    go = 1'b0; abort = 1'b1;
    @(negedge ap_clk);
    abort = 1'b0;
    wait_idle("abload");
    check("abload_rises", n_rise, 0);
    check("abload_done", done_cnt, 1);
    check("abload_err", err_cnt, 1);

    // Table write while busy is dropped
    clear_mon();
    go_pulse(2);
    wait_rise(1);
    wr(1, pack(3, 1, 2, 99));
    wait_idle("wbusy");
    check("wbusy_rises", n_rise, 2);
    check("wbusy_l1_ch", snap_ch[1], 32);
    check("wbusy_l1_s", snap_s[1], 2);

    // Write and go in the same cycle: write lands first
    clear_mon();
    @(negedge ap_clk);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_wdata = pack(2, 50, 60, 70);
    num_layers = 3'd1; go = 1'b1;
    @(negedge ap_clk);
    cfg_we = 1'b0; go = 1'b0;
    wait_idle("wgo");
    check("wgo_rises", n_rise, 1);
    check("wgo_cfg", snap_ch[0] * 1000000 + snap_h[0] * 1000 + snap_w[0], 70060050);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
